// File: rtl/vector_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : vector_pkg                                                      |
// | Brief    : Opcodes, packet-length lookup and buffer depth shared by the    |
// |            vector command encoder and the vector engine.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package vector_pkg;

  localparam logic [7:0] SET_COLOR_PAL = 8'h10;
  localparam logic [7:0] MOVE          = 8'h11;
  localparam logic [7:0] LINE          = 8'h13;
  localparam logic [7:0] QUAD_CURVE    = 8'h14;
  localparam logic [7:0] CUB_CURVE     = 8'h15;
  localparam logic [7:0] SET_COLOR_IDX = 8'h18;
  localparam logic [7:0] SHOW          = 8'h19;

  localparam int MAX_PKT_BYTES = 13;

  // Zero marks an opcode the encoder does not emit (QUAD_CURVE included).
  function automatic logic [3:0] pkt_len(input logic [7:0] opcode);
    case (opcode)
      SET_COLOR_PAL: pkt_len = 4'd4;
      MOVE:          pkt_len = 4'd5;
      LINE:          pkt_len = 4'd5;
      CUB_CURVE:     pkt_len = 4'd13;
      SET_COLOR_IDX: pkt_len = 4'd2;
      SHOW:          pkt_len = 4'd1;
      default:       pkt_len = 4'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/vector_cmd_encoder.sv
// +----------------------------------------------------------------------------+
// | Module   : vector_cmd_encoder                                              |
// | Brief    : Serialises one draw command per handshake into the byte packet  |
// |            stream of the vector FIFO. Define VECTOR_ENC_STATS_EN to add    |
// |            the cmd_count packet counter.                                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module vector_cmd_encoder
  import vector_pkg::*;
#(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [7:0]         cmd_opcode,
  input  logic [X_WIDTH-1:0] cmd_x1,
  input  logic [X_WIDTH-1:0] cmd_x2,
  input  logic [X_WIDTH-1:0] cmd_x3,
  input  logic [Y_WIDTH-1:0] cmd_y1,
  input  logic [Y_WIDTH-1:0] cmd_y2,
  input  logic [Y_WIDTH-1:0] cmd_y3,
  input  logic [3:0]         cmd_color_idx,
  input  logic [9:0]         cmd_color_code,
  output logic               fifo_wr_en,
  output logic [7:0]         fifo_wr_data,
  input  logic               fifo_full,
  output logic               busy,
  output logic               err_opcode
`ifdef VECTOR_ENC_STATS_EN
  ,
  output logic [15:0]        cmd_count
`endif
);

  localparam logic [0:0] c_state_idle = 1'b0;
  localparam logic [0:0] c_state_emit = 1'b1;

  logic [0:0]                    r_state;
  logic [3:0]                    r_idx;
  logic [3:0]                    r_len;
  logic [MAX_PKT_BYTES-1:0][7:0] r_buf;
  logic                          r_err;

  logic [15:0]                   w_x1, w_x2, w_x3;
  logic [15:0]                   w_y1, w_y2, w_y3;
  logic [MAX_PKT_BYTES-1:0][7:0] w_pkt;
  logic [3:0]                    w_len;
  logic                          w_emit;
  logic                          w_last_xfer;

  assign w_len       = pkt_len(cmd_opcode);
  assign w_emit      = (r_state == c_state_emit);
  assign w_last_xfer = w_emit && !fifo_full && (r_idx == r_len - 4'd1);

  assign cmd_ready    = !w_emit;
  assign busy         = w_emit;
  assign err_opcode   = r_err;
  assign fifo_wr_en   = w_emit && !fifo_full;
  assign fifo_wr_data = w_emit ? r_buf[r_idx] : 8'h00;

  // Coordinates travel as 16-bit fields; bits above the native width stay zero.
  always_comb begin
    w_x1 = '0;
    w_x2 = '0;
    w_x3 = '0;
    w_y1 = '0;
    w_y2 = '0;
    w_y3 = '0;
    w_x1[X_WIDTH-1:0] = cmd_x1;
    w_x2[X_WIDTH-1:0] = cmd_x2;
    w_x3[X_WIDTH-1:0] = cmd_x3;
    w_y1[Y_WIDTH-1:0] = cmd_y1;
    w_y2[Y_WIDTH-1:0] = cmd_y2;
    w_y3[Y_WIDTH-1:0] = cmd_y3;
  end

  always_comb begin
    w_pkt    = '0;
    w_pkt[0] = cmd_opcode;
    case (cmd_opcode)
      SET_COLOR_PAL: begin
        w_pkt[1] = {4'b0000, cmd_color_idx};
        w_pkt[2] = {6'b000000, cmd_color_code[9:8]};
        w_pkt[3] = cmd_color_code[7:0];
      end
      MOVE, LINE: begin
        w_pkt[1] = w_x1[15:8];
        w_pkt[2] = w_x1[7:0];
        w_pkt[3] = w_y1[15:8];
        w_pkt[4] = w_y1[7:0];
      end
      CUB_CURVE: begin
        w_pkt[1]  = w_x1[15:8];
        w_pkt[2]  = w_x1[7:0];
        w_pkt[3]  = w_y1[15:8];
        w_pkt[4]  = w_y1[7:0];
        w_pkt[5]  = w_x2[15:8];
        w_pkt[6]  = w_x2[7:0];
        w_pkt[7]  = w_y2[15:8];
        w_pkt[8]  = w_y2[7:0];
        w_pkt[9]  = w_x3[15:8];
        w_pkt[10] = w_x3[7:0];
        w_pkt[11] = w_y3[15:8];
        w_pkt[12] = w_y3[7:0];
      end
      SET_COLOR_IDX: begin
        w_pkt[1] = {4'b0000, cmd_color_idx};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_state_idle;
      r_idx   <= 4'd0;
      r_len   <= 4'd0;
      r_buf   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        c_state_idle: begin
          if (cmd_valid) begin
            // Unsupported opcodes are consumed here and only flagged.
            if (w_len != 4'd0) begin
              r_buf   <= w_pkt;
              r_len   <= w_len;
              r_idx   <= 4'd0;
              r_state <= c_state_emit;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          if (!fifo_full) begin
            if (w_last_xfer) begin
              r_idx   <= 4'd0;
              r_state <= c_state_idle;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef VECTOR_ENC_STATS_EN
  logic [15:0] r_cmd_count;

  assign cmd_count = r_cmd_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_count <= 16'h0000;
    end else if (w_last_xfer && (r_cmd_count != 16'hFFFF)) begin
      r_cmd_count <= r_cmd_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vector_cmd_encoder.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_vector_cmd_encoder                                           |
// | Brief    : Directed self-checking bench for vector_cmd_encoder.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vector_cmd_encoder;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_opcode;
  logic [9:0] cmd_x1, cmd_x2, cmd_x3;
  logic [8:0] cmd_y1, cmd_y2, cmd_y3;
  logic [3:0] cmd_color_idx;
  logic [9:0] cmd_color_code;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       fifo_full;
  logic       busy;
  logic       err_opcode;
`ifdef VECTOR_ENC_STATS_EN
  logic [15:0] cmd_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] got [16];
  int         n_got;
  int         ready_low;
  int         first_wr;

  vector_cmd_encoder #(.X_WIDTH(10), .Y_WIDTH(9)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opcode     (cmd_opcode),
    .cmd_x1         (cmd_x1),
    .cmd_x2         (cmd_x2),
    .cmd_x3         (cmd_x3),
    .cmd_y1         (cmd_y1),
    .cmd_y2         (cmd_y2),
    .cmd_y3         (cmd_y3),
    .cmd_color_idx  (cmd_color_idx),
    .cmd_color_code (cmd_color_code),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_data   (fifo_wr_data),
    .fifo_full      (fifo_full),
    .busy           (busy),
    .err_opcode     (err_opcode)
`ifdef VECTOR_ENC_STATS_EN
    ,
    .cmd_count      (cmd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle handshake, then scramble the inputs so latching is exercised.
  task automatic send_cmd(input logic [7:0] op, input logic [9:0] x1, input logic [8:0] y1,
                          input logic [9:0] x2, input logic [8:0] y2,
                          input logic [9:0] x3, input logic [8:0] y3,
                          input logic [3:0] idx, input logic [9:0] code);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op;
    cmd_x1 = x1; cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2; cmd_x3 = x3; cmd_y3 = y3;
    cmd_color_idx = idx; cmd_color_code = code;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_opcode = 8'h13;
    cmd_x1 = 10'h155; cmd_y1 = 9'h0AA; cmd_x2 = 10'h2AA; cmd_y2 = 9'h155;
    cmd_x3 = 10'h3C3; cmd_y3 = 9'h13C; cmd_color_idx = 4'hF; cmd_color_code = 10'h3FF;
  endtask

  // Record written bytes until the encoder goes idle; cmd_valid is pulsed
  // during the packet to show that it is ignored while busy.
  task automatic collect(input bit toggle_full, input int max_cycles);
    n_got = 0; ready_low = 0; first_wr = -1;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      fifo_full = toggle_full ? cyc[0] : 1'b0;
      cmd_valid = (cyc == 1);
      #1;
      if (!cmd_ready) ready_low++;
      if (fifo_wr_en) begin
        if (first_wr < 0) first_wr = cyc;
        if (n_got < 16) got[n_got] = fifo_wr_data;
        n_got++;
      end
      if (!busy) break;
    end
    fifo_full = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #13;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || fifo_wr_en !== 1'b0 ||
        fifo_wr_data !== 8'h00 || err_opcode !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b busy=%b wr_en=%b data=%h err=%b, required 1 0 0 00 0",
               cmd_ready, busy, fifo_wr_en, fifo_wr_data, err_opcode);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_line();
    logic [7:0] exp [5];
    exp = '{8'h13, 8'h02, 8'hA5, 8'h01, 8'hF0};
    send_cmd(8'h13, 10'h2A5, 9'h1F0, 10'h0, 9'h0, 10'h0, 9'h0, 4'h0, 10'h0);
    collect(1'b0, 40);
    checks++;
    if (n_got !== 5) begin
      errors++;
      $display("FAIL line_count: got %0d bytes, required 5", n_got);
    end
    checks++;
    if (first_wr !== 0) begin
      errors++;
      $display("FAIL line_latency: first write in cycle %0d, required 0", first_wr);
    end
    checks++;
    if (ready_low !== 5) begin
      errors++;
      $display("FAIL line_ready_low: %0d cycles, required 5", ready_low);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL line_byte%0d: got %h, required %h", i, got[i], exp[i]);
      end
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL line_ready_after: got %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_cub_curve();
    logic [7:0] exp [13];
    exp = '{8'h15, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03, 8'hFF,
            8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h80};
    send_cmd(8'h15, 10'h001, 9'h002, 10'h3FF, 9'h1FF, 10'h100, 9'h080, 4'h0, 10'h0);
    collect(1'b1, 60);
    checks++;
    if (n_got !== 13) begin
      errors++;
      $display("FAIL cub_count: got %0d bytes, required 13", n_got);
    end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL cub_byte%0d: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_color();
    logic [7:0] exp [4];
    exp = '{8'h10, 8'h05, 8'h02, 8'hC3};
    send_cmd(8'h10, 10'h0, 9'h0, 10'h0, 9'h0, 10'h0, 9'h0, 4'h5, 10'h2C3);
    collect(1'b0, 40);
    checks++;
    if (n_got !== 4) begin
      errors++;
      $display("FAIL pal_count: got %0d bytes, required 4", n_got);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL pal_byte%0d: got %h, required %h", i, got[i], exp[i]);
      end
    end
    send_cmd(8'h18, 10'h0, 9'h0, 10'h0, 9'h0, 10'h0, 9'h0, 4'h9, 10'h0);
    collect(1'b0, 40);
    checks++;
    if (n_got !== 2 || got[0] !== 8'h18 || got[1] !== 8'h09) begin
      errors++;
      $display("FAIL idx_packet: got %0d bytes %h %h, required 2 bytes 18 09",
               n_got, got[0], got[1]);
    end
  endtask

  task automatic test_show();
    send_cmd(8'h19, 10'h0, 9'h0, 10'h0, 9'h0, 10'h0, 9'h0, 4'h0, 10'h0);
    collect(1'b0, 40);
    checks++;
    if (n_got !== 1 || got[0] !== 8'h19) begin
      errors++;
      $display("FAIL show_packet: got %0d bytes first %h, required 1 byte 19", n_got, got[0]);
    end
  endtask

  task automatic test_bad_opcode();
    send_cmd(8'h14, 10'h2A5, 9'h1F0, 10'h0, 9'h0, 10'h0, 9'h0, 4'h0, 10'h0);
    @(negedge clk);
    checks++;
    if (err_opcode !== 1'b1 || fifo_wr_en !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_op_pulse: err=%b wr_en=%b ready=%b busy=%b, required 1 0 1 0",
               err_opcode, fifo_wr_en, cmd_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (err_opcode !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL bad_op_after: err=%b wr_en=%b, required 0 0", err_opcode, fifo_wr_en);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] exp [5];
    exp = '{8'h13, 8'h00, 8'h42, 8'h00, 8'h21};
    send_cmd(8'h11, 10'h1AB, 9'h0CD, 10'h0, 9'h0, 10'h0, 9'h0, 4'h0, 10'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hAB) begin
      errors++;
      $display("FAIL move_third_byte: wr_en=%b data=%h, required 1 AB", fifo_wr_en, fifo_wr_data);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || fifo_wr_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: wr_en=%b busy=%b ready=%b data=%h, required 0 0 1 00",
               fifo_wr_en, busy, cmd_ready, fifo_wr_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    send_cmd(8'h13, 10'h042, 9'h021, 10'h0, 9'h0, 10'h0, 9'h0, 4'h0, 10'h0);
    collect(1'b0, 40);
    checks++;
    if (n_got !== 5) begin
      errors++;
      $display("FAIL post_reset_count: got %0d bytes, required 5", n_got);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL post_reset_byte%0d: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask

`ifdef VECTOR_ENC_STATS_EN
  task automatic test_stats();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    send_cmd(8'h19, 10'h0, 9'h0, 10'h0, 9'h0, 10'h0, 9'h0, 4'h0, 10'h0);
    collect(1'b0, 40);
    send_cmd(8'h14, 10'h0, 9'h0, 10'h0, 9'h0, 10'h0, 9'h0, 4'h0, 10'h0);
    @(negedge clk);
    send_cmd(8'h13, 10'h1, 9'h1, 10'h0, 9'h0, 10'h0, 9'h0, 4'h0, 10'h0);
    collect(1'b1, 40);
    send_cmd(8'h18, 10'h0, 9'h0, 10'h0, 9'h0, 10'h0, 9'h0, 4'h3, 10'h0);
    collect(1'b0, 40);
    checks++;
    if (cmd_count !== 16'd3) begin
      errors++;
      $display("FAIL stats_count: got %0d, required 3", cmd_count);
    end
    @(negedge clk);
    force dut.r_cmd_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_cmd_count;
    send_cmd(8'h19, 10'h0, 9'h0, 10'h0, 9'h0, 10'h0, 9'h0, 4'h0, 10'h0);
    collect(1'b0, 40);
    checks++;
    if (cmd_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_saturate: got %h, required FFFF", cmd_count);
    end
  endtask
`endif

  initial begin
    cmd_valid = 1'b0; cmd_opcode = 8'h00; fifo_full = 1'b0;
    cmd_x1 = '0; cmd_x2 = '0; cmd_x3 = '0;
    cmd_y1 = '0; cmd_y2 = '0; cmd_y3 = '0;
    cmd_color_idx = '0; cmd_color_code = '0;
    test_reset();
    test_line();
    test_cub_curve();
    test_color();
    test_show();
    test_bad_opcode();
    test_reset_mid_packet();
`ifdef VECTOR_ENC_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
